// File: rtl/algo_2ror1w_req_sched_pkg.sv
// Shared types and helpers for the 2R/1W request scheduler: read-port count,
// per-port return tag and the round-robin pointer advance.
package algo_2ror1w_req_sched_pkg;

   localparam int NUM_RD_PORTS = 2;
   localparam int MAX_BITCLNT  = 4;

   // Client id is sized for the largest supported client count (16).
   typedef struct packed {
      logic                   vld;
      logic [MAX_BITCLNT-1:0] id;
   } rd_tag_t;

   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/algo_2ror1w_req_sched_if.sv
// Client- and macro-side signal bundle of the 2R/1W request scheduler.
interface algo_2ror1w_req_sched_if #(
   parameter int NUMCLNT = 4,
   parameter int WIDTH   = 32,
   parameter int BITADDR = 13
);
   logic                       ready;
   logic [NUMCLNT-1:0]         cl_read;
   logic [NUMCLNT*BITADDR-1:0] cl_adr;
   logic [NUMCLNT-1:0]         cl_gnt;
   logic [NUMCLNT-1:0]         cl_vld;
   logic [NUMCLNT*WIDTH-1:0]   cl_dout;
   logic                       wr_req;
   logic [BITADDR-1:0]         wr_adr_in;
   logic [WIDTH-1:0]           wr_din;
   logic                       wr_gnt;
   logic [1:0]                 read;
   logic [2*BITADDR-1:0]       rd_adr;
   logic [1:0]                 rd_vld;
   logic [2*WIDTH-1:0]         rd_dout;
   logic                       write;
   logic [BITADDR-1:0]         wr_adr;
   logic [WIDTH-1:0]           din;
   logic                       refr;
   logic                       tag_err;

   modport slave (
      input  ready, cl_read, cl_adr, wr_req, wr_adr_in, wr_din, rd_vld, rd_dout,
      output cl_gnt, cl_vld, cl_dout, wr_gnt, read, rd_adr, write, wr_adr, din, refr, tag_err
   );

   modport master (
      output ready, cl_read, cl_adr, wr_req, wr_adr_in, wr_din, rd_vld, rd_dout,
      input  cl_gnt, cl_vld, cl_dout, wr_gnt, read, rd_adr, write, wr_adr, din, refr, tag_err
   );
endinterface

// File: rtl/algo_2ror1w_req_sched_tag_pipe.sv
// Per-read-port tag delay line: carries {valid, client id} from issue to the
// cycle the macro returns data for that read.
module algo_sched_tag_pipe
   import algo_2ror1w_req_sched_pkg::*;
#(
   parameter int RD_DELAY = 3,
   parameter int BITCLNT  = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_vld,
   input  logic [BITCLNT-1:0] in_id,
   output rd_tag_t            out_tag
);

   rd_tag_t stage_q [RD_DELAY];
   rd_tag_t stage_d [RD_DELAY];

   always_comb begin
      stage_d[0].vld = in_vld;
      stage_d[0].id  = MAX_BITCLNT'(in_id);
      for (int i = 1; i < RD_DELAY; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RD_DELAY; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q <= stage_d;
      end
   end

   assign out_tag = stage_q[RD_DELAY-1];

endmodule

// File: rtl/algo_2ror1w_req_sched.sv
// Round-robin read scheduler, write pass-through and refresh insertion in front
// of the 2R/1W macro. Refresh insertion is built only with ALGO_SCHED_REFR_EN.
module algo_2ror1w_req_sched
   import algo_2ror1w_req_sched_pkg::*;
#(
   parameter int NUMCLNT  = 4,
   parameter int BITCLNT  = 2,
   parameter int WIDTH    = 32,
   parameter int BITADDR  = 13,
   parameter int RD_DELAY = 3,
   parameter int REFFREQ  = 6
) (
   input logic                    clk,
   input logic                    rst,
   algo_2ror1w_req_sched_if.slave bus
);

   logic                       blocked;
   logic                       refr_slot;
   logic [BITCLNT-1:0]         rr_ptr_q, rr_ptr_d;
   logic [NUM_RD_PORTS-1:0]    g_vld;
   logic [BITCLNT-1:0]         g_id [NUM_RD_PORTS];
   logic [BITCLNT:0]           scan_sum;
   logic [BITCLNT-1:0]         scan_idx;
   logic [BITCLNT-1:0]         last_id;
   logic [NUMCLNT-1:0]         cl_gnt;
   logic                       wr_gnt;

   logic [1:0]                 read_q, read_d;
   logic [2*BITADDR-1:0]       rd_adr_q, rd_adr_d;
   logic [BITCLNT-1:0]         rd_id_q [NUM_RD_PORTS];
   logic [BITCLNT-1:0]         rd_id_d [NUM_RD_PORTS];
   logic                       write_q, write_d;
   logic [BITADDR-1:0]         wr_adr_q, wr_adr_d;
   logic [WIDTH-1:0]           din_q, din_d;
   logic                       refr_q, refr_d;
   logic [NUMCLNT-1:0]         cl_vld_q, cl_vld_d;
   logic [NUMCLNT*WIDTH-1:0]   cl_dout_q, cl_dout_d;
   logic                       tag_err_q, tag_err_d;
   rd_tag_t                    tag [NUM_RD_PORTS];

`ifdef ALGO_SCHED_REFR_EN
   localparam int REF_W = $clog2(REFFREQ);
   logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;

   // Counter parks at 0 while the macro is not ready.
   always_comb begin
      refr_slot = bus.ready && (ref_cnt_q == REF_W'(REFFREQ - 1));
      ref_cnt_d = ref_cnt_q + 1'b1;
      if (!bus.ready || ref_cnt_q == REF_W'(REFFREQ - 1)) ref_cnt_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ref_cnt_q <= '0;
      else     ref_cnt_q <= ref_cnt_d;
   end
`else
   assign refr_slot = 1'b0;
`endif

   assign blocked = !bus.ready || refr_slot;

   // Circular scan from rr_ptr: first requester takes port 0, second port 1.
   always_comb begin
      g_vld    = '0;
      g_id[0]  = '0;
      g_id[1]  = '0;
      scan_sum = '0;
      scan_idx = '0;
      cl_gnt   = '0;
      last_id  = '0;
      rr_ptr_d = rr_ptr_q;
      if (!blocked) begin
         for (int k = 0; k < NUMCLNT; k++) begin
            scan_sum = {1'b0, rr_ptr_q} + (BITCLNT+1)'(k);
            if (scan_sum >= (BITCLNT+1)'(NUMCLNT)) scan_sum = scan_sum - (BITCLNT+1)'(NUMCLNT);
            scan_idx = scan_sum[BITCLNT-1:0];
            if (bus.cl_read[scan_idx]) begin
               if (!g_vld[0]) begin
                  g_vld[0] = 1'b1;
                  g_id[0]  = scan_idx;
               end else if (!g_vld[1]) begin
                  g_vld[1] = 1'b1;
                  g_id[1]  = scan_idx;
               end
            end
         end
      end
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
         if (g_vld[p]) cl_gnt[g_id[p]] = 1'b1;
      end
      if (g_vld[1])      last_id = g_id[1];
      else if (g_vld[0]) last_id = g_id[0];
      if (g_vld[0]) rr_ptr_d = BITCLNT'(rr_next(32'(last_id), NUMCLNT));
   end

   assign wr_gnt = bus.wr_req && !blocked;

   always_comb begin
      read_d   = g_vld;
      rd_adr_d = '0;
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
         rd_id_d[p] = g_vld[p] ? g_id[p] : '0;
         if (g_vld[p]) rd_adr_d[p*BITADDR +: BITADDR] = bus.cl_adr[g_id[p]*BITADDR +: BITADDR];
      end
      write_d  = wr_gnt;
      wr_adr_d = wr_gnt ? bus.wr_adr_in : '0;
      din_d    = wr_gnt ? bus.wr_din : '0;
      refr_d   = refr_slot;
   end

   // Returning data is steered by the tag that left issue RD_DELAY cycles ago.
   always_comb begin
      cl_vld_d  = '0;
      cl_dout_d = cl_dout_q;
      tag_err_d = tag_err_q;
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
         if (bus.rd_vld[p]) begin
            if (tag[p].vld) begin
               for (int c = 0; c < NUMCLNT; c++) begin
                  if (tag[p].id == MAX_BITCLNT'(c)) begin
                     cl_vld_d[c]                  = 1'b1;
                     cl_dout_d[c*WIDTH +: WIDTH] = bus.rd_dout[p*WIDTH +: WIDTH];
                  end
               end
            end else begin
               tag_err_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q  <= '0;
         read_q    <= '0;
         rd_adr_q  <= '0;
         rd_id_q[0] <= '0;
         rd_id_q[1] <= '0;
         write_q   <= 1'b0;
         wr_adr_q  <= '0;
         din_q     <= '0;
         refr_q    <= 1'b0;
         cl_vld_q  <= '0;
         cl_dout_q <= '0;
         tag_err_q <= 1'b0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         read_q    <= read_d;
         rd_adr_q  <= rd_adr_d;
         rd_id_q   <= rd_id_d;
         write_q   <= write_d;
         wr_adr_q  <= wr_adr_d;
         din_q     <= din_d;
         refr_q    <= refr_d;
         cl_vld_q  <= cl_vld_d;
         cl_dout_q <= cl_dout_d;
         tag_err_q <= tag_err_d;
      end
   end

   for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_tag
      algo_sched_tag_pipe #(
         .RD_DELAY (RD_DELAY),
         .BITCLNT  (BITCLNT)
      ) u_tag_pipe (
         .clk     (clk),
         .rst     (rst),
         .in_vld  (read_q[p]),
         .in_id   (rd_id_q[p]),
         .out_tag (tag[p])
      );
   end

   assign bus.cl_gnt  = cl_gnt;
   assign bus.wr_gnt  = wr_gnt;
   assign bus.read    = read_q;
   assign bus.rd_adr  = rd_adr_q;
   assign bus.write   = write_q;
   assign bus.wr_adr  = wr_adr_q;
   assign bus.din     = din_q;
   assign bus.refr    = refr_q;
   assign bus.cl_vld  = cl_vld_q;
   assign bus.cl_dout = cl_dout_q;
   assign bus.tag_err = tag_err_q;

endmodule

// File: doc/algo_2ror1w_req_sched.md
# algo_2ror1w_req_sched

Request scheduler in front of the 2-read/1-write duplicated memory macro. Arbitrates NUMCLNT independent read clients onto the two physical read ports with round-robin fairness, passes a single write client through with a grant handshake, and inserts periodic refresh cycles. Read data returning from the macro is routed back to the originating client through a tag pipeline matched to the macro read latency.

## Interface
- NUMCLNT, 4, number of read clients (2..16)
- BITCLNT, 2, clog2(NUMCLNT)
- WIDTH, 32, data width
- BITADDR, 13, address width
- RD_DELAY, 3, macro latency: cycles from `read` sampled to `rd_vld` (>=1)
- REFFREQ, 6, refresh period in cycles (>=2)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, reset asynchronous and active-high
- ready  in  1  macro ready
- cl_read  in  NUMCLNT  per-client read request, held until granted
- cl_adr  in  NUMCLNT*BITADDR  per-client read address
- cl_gnt  out  NUMCLNT  combinational grant, request consumed this cycle
- cl_vld  out  NUMCLNT  registered read-data valid per client
- cl_dout  out  NUMCLNT*WIDTH  registered read data per client
- wr_req  in  1  write request, held until granted
- wr_adr_in  in  BITADDR  write address
- wr_din  in  WIDTH  write data
- wr_gnt  out  1  combinational write grant
- read  out  2  macro read strobes (registered)
- rd_adr  out  2*BITADDR  macro read addresses (registered)
- rd_vld  in  2  macro read valid
- rd_dout  in  2*WIDTH  macro read data
- write  out  1  macro write strobe (registered)
- wr_adr  out  BITADDR  macro write address (registered)
- din  out  WIDTH  macro write data (registered)
- refr  out  1  macro refresh strobe (registered)
- tag_err  out  1  sticky: `rd_vld` seen with no matching tag

## Operation
- Blocked cycle: `ready`=0 or refresh slot (ref_cnt==REFFREQ-1). No grants issued.
- Read arbitration: scan clients circularly starting at rr_ptr; first requester gets port 0, second gets port 1. rr_ptr <= (last granted index + 1) mod NUMCLNT; unchanged when no grant.
- Write: wr_gnt = wr_req & ~blocked. Independent of reads; same-address read/write in one cycle is resolved by the macro.
- Issue register: granted requests become `read`/`rd_adr`/`write`/`wr_adr`/`din` next cycle; ungranted ports drive strobe 0, address 0.
- Tag pipeline: per port, RD_DELAY-deep shift of {valid, client id} loaded at issue. When `rd_vld[p]` is set and the tag at depth RD_DELAY is valid, register `rd_dout[p]` to that client's `cl_dout` and set its `cl_vld` for one cycle. Both ports never target one client in the same cycle (distinct grants).
- `rd_vld[p]` with invalid tag: data dropped, tag_err <= 1 until reset.
- ref_cnt: 0..REFFREQ-1 wrapping, held at 0 while `ready`=0.

## Timing
- Reset: all registered outputs 0, rr_ptr=0, ref_cnt=0, tags invalid, tag_err=0.
- Grant in cycle t -> `read` in t+1 -> `rd_vld` in t+1+RD_DELAY -> `cl_vld` in t+2+RD_DELAY.
- Refresh: `refr`=1 for one cycle in the cycle after the refresh slot; that cycle has read=0, write=0.
- Reset asserted mid-operation: in-flight tags discarded; late `rd_vld` after reset release flags tag_err.
- `ready` deasserting: outstanding tags still drain normally.

## Configuration
- ALGO_SCHED_REFR_EN defined: refresh counter and slot blocking as above.
- Undefined: no counter, `refr` tied 0, blocked = ~ready only.

## Structure
- Shared package: per-port tag struct {vld, client id}, port-count constant 2, round-robin helper function.
- One sub-module: algo_sched_tag_pipe (one instance per read port), parameterised on RD_DELAY and BITCLNT.

## Test plan
- Reset, ready=1, cl_read=4'b1111, REFFREQ=6: cycle 1 grants clients 0,1; cycle 2 grants 2,3; rr_ptr wraps to 0.
- Single read client 2, addr 0x0A5, macro returns 0xDEADBEEF at RD_DELAY=3: cl_vld[2] exactly 5 cycles after grant with data 0xDEADBEEF.
- ALGO_SCHED_REFR_EN, continuous requests: refr every 6th cycle; no read/write strobe in refr cycles; all requests eventually granted.
- ready=0 for 10 cycles with wr_req=1: wr_gnt=0, refr=0, ref_cnt frozen; wr_gnt=1 first cycle ready=1.
- Inject rd_vld[1]=1 with no outstanding read: tag_err=1 and stays set; no cl_vld.
- Assert rst with 2 reads in flight: outputs zero immediately (async); post-release rd_vld sets tag_err.
